decision_sequencer: RTL and testbench
=====================================

Name: decision_sequencer

Overview:
- Downstream of the debounced IR decision stage.
- Consumes the stage's debounced decision code and done strobe and turns each new decision into a single action command for the drive/actuator logic.
- Issues the command over a valid/ready handshake, then holds the action for a fixed time and runs a cooldown.
- STOP preempts any action in progress; the block then parks in a halted state until a new movement decision arrives.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles an accepted non-STOP action is held after handshake (must be ≥1).
- COOL_CYCLES, 10_000_000: cooldown cycles after HOLD, during which new non-STOP decisions are not started (must be ≥1).
- CNT_W, 26: width of the shared hold/cool down-counter; must hold max(HOLD_CYCLES, COOL_CYCLES)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  debounced decision strobe (finalDone of the decision stage).
- dec_code  in  3  decision code: NONE=0, R_B=1, R_G=2, B_G=3, STOP=4; 5..7 illegal.
- cmd_ready  in  1  actuator accepts the command this cycle.
- cmd_valid  out  1  command offered.
- cmd_code  out  3  command payload; stable while cmd_valid=1.
- busy  out  1  high in ISSUE, HOLD or COOL.
- halted  out  1  high in HALT.
- state  out  3  IDLE=0, ISSUE=1, HOLD=2, COOL=3, HALT=4.
- dropped  out  1  one-cycle pulse: a legal non-STOP decision was discarded.
- err  out  1  one-cycle pulse: a decision edge carried code 0 or 5..7.

Behaviour:
- Reset values: state=IDLE, cmd_valid=0, cmd_code=0, busy=0, halted=0, dropped=0, err=0. Counter, edge register and pending STOP flag are cleared.
- Reset mid-handshake drops cmd_valid on the next cycle regardless of cmd_ready. Reset has priority over every other event.
- Edge detection: a decision event is dec_valid=1 this cycle and 0 the previous cycle. The registered copy of dec_valid resets to 0. A level held high produces one event only; dec_code is sampled on the event cycle.
- Illegal code on an event: err pulses the next cycle; state and outputs are otherwise unchanged.
- Latency: an event in cycle N gives cmd_valid=1 in cycle N+1.
- IDLE: a legal event (1..4) latches cmd_code and moves to ISSUE.
- ISSUE: cmd_valid=1 until cmd_ready=1 is sampled; cmd_valid=0 the following cycle.
  - On handshake with a non-STOP code: go to HOLD, counter loaded with HOLD_CYCLES-1.
  - On handshake with STOP: go to HALT.
  - A STOP event during ISSUE sets the pending-STOP flag. After the current handshake, the block re-enters ISSUE with cmd_code=STOP, and cmd_valid reasserts one cycle after dropping.
  - If the event and handshake fall in the same cycle, the flag is still set.
- HOLD: decrements each cycle; at 0 goes to COOL, counter loaded with COOL_CYCLES-1. Total hold is exactly HOLD_CYCLES cycles.
- COOL: decrements each cycle; at 0 goes to IDLE.
- STOP event in HOLD or COOL: abort immediately, go to ISSUE with cmd_code=STOP.
- Non-STOP event in ISSUE, HOLD or COOL: dropped pulses; the event is otherwise ignored (see Optional Feature).
- HALT: a STOP event is ignored silently; an event with code 1..3 latches it and goes to ISSUE.
- An event on the same cycle a counter expires is treated by the current (pre-transition) state.
- Counter arithmetic is unsigned CNT_W bits and never wraps; it only loads and decrements.

Optional Feature:
- Macro: DECISION_SEQ_QUEUE_EN.
- When defined:
  - A one-entry pending buffer captures non-STOP events arriving in ISSUE, HOLD or COOL. The latest event overwrites the entry, and dropped pulses only on overwrite.
  - On COOL→IDLE, a valid entry goes straight to ISSUE with cmd_valid on the first IDLE-exit cycle, and the entry is cleared.
  - STOP, reset or entry to HALT clears the buffer.
- When undefined: no buffer; every such event pulses dropped.

Test Plan (HOLD_CYCLES=4, COOL_CYCLES=3):
- Basic flow, cmd_ready tied 1: dec_valid rises with code 2 at cycle 10.
  - cmd_valid=1 and cmd_code=2 at cycle 11.
  - state HOLD for cycles 12-15, COOL for 16-18, IDLE at 19.
- Backpressure: same stimulus with cmd_ready low until cycle 14.
  - cmd_valid held with cmd_code=2 stable over cycles 11-14, then 0 at cycle 15.
- STOP preempt: code 1 accepted, then STOP event during HOLD.
  - Next cycle cmd_valid=1 with cmd_code=4.
  - After handshake, halted=1 and state=4.
  - A further STOP event: no output change.
  - Code 3 event: ISSUE with cmd_code=3, halted=0.
- Filtering: dec_valid held high 20 cycles with code 1 gives exactly one command.
  - Code 6 edge in IDLE: err pulse, no cmd_valid.
  - Code 3 edge during COOL: dropped pulse (queue off), no command.
- Queue (DECISION_SEQ_QUEUE_EN): events with code 2 then code 3 during HOLD.
  - One dropped pulse.
  - After COOL, cmd_code=3 is issued without a new event.
- Reset: assert rst while cmd_valid=1 and cmd_ready=0.
  - All outputs at reset values next cycle; dec_valid already high after reset produces no event.

Source files
------------

// File: rtl/decision_sequencer.sv
// decision_sequencer: turns each debounced IR decision into one handshaked
// actuator command, then holds it, cools down, and lets STOP preempt.
// Ports: clk, rst (sync, active-high); dec_valid/dec_code decision in;
// cmd_valid/cmd_ready/cmd_code command handshake out;
// busy, halted, state, dropped, err status out.
// Optional: define DECISION_SEQ_QUEUE_EN to buffer one decision while busy.
module decision_sequencer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned COOL_CYCLES = 10_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [2:0] dec_code,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       busy,
  output logic       halted,
  output logic [2:0] state,
  output logic       dropped,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_HOLD  = 3'd2,
    S_COOL  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [2:0] C_STOP = 3'd4;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOL_CYCLES - 1);

  state_e           state_q;
  logic             cmd_valid_q;
  logic [2:0]       cmd_code_q;
  logic             dropped_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dv_q;
  logic             blk_q;
  logic             pend_q;
`ifdef DECISION_SEQ_QUEUE_EN
  logic             q_vld_q;
  logic [2:0]       q_code_q;
`endif

  logic ev;
  logic legal;
  logic ev_go;
  logic ev_stop;
  logic stop_now;
  logic busy_st;
  logic hs;

  // blk_q remembers a level already high during reset so it is not
  // mistaken for a fresh decision once reset releases.
  assign ev       = dec_valid & ~dv_q & ~blk_q;
  assign legal    = (dec_code != 3'd0) && (dec_code <= C_STOP);
  assign ev_go    = ev & legal & (dec_code != C_STOP);
  assign ev_stop  = ev & (dec_code == C_STOP);
  // A STOP arriving while STOP itself is being offered adds nothing.
  assign stop_now = ev_stop & (cmd_code_q != C_STOP);
  assign busy_st  = (state_q == S_ISSUE) || (state_q == S_HOLD)
                 || (state_q == S_COOL);
  assign hs       = cmd_valid_q & cmd_ready;

  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign state     = state_q;
  assign busy      = busy_st;
  assign halted    = (state_q == S_HALT);
  assign dropped   = dropped_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    dropped_q <= 1'b0;
    err_q     <= 1'b0;
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      cnt_q       <= '0;
      dv_q        <= 1'b0;
      blk_q       <= dec_valid;
      pend_q      <= 1'b0;
`ifdef DECISION_SEQ_QUEUE_EN
      q_vld_q     <= 1'b0;
      q_code_q    <= 3'd0;
`endif
    end else begin
      dv_q <= dec_valid;
      if (!dec_valid) blk_q <= 1'b0;
      if (ev && !legal) err_q <= 1'b1;

      // Movement decisions while busy: buffer or discard.
      if (ev_go && busy_st) begin
`ifdef DECISION_SEQ_QUEUE_EN
        dropped_q <= q_vld_q;
        q_vld_q   <= 1'b1;
        q_code_q  <= dec_code;
`else
        dropped_q <= 1'b1;
`endif
      end
`ifdef DECISION_SEQ_QUEUE_EN
      if (ev_stop && busy_st) q_vld_q <= 1'b0;
`endif

      unique case (state_q)
        S_IDLE: begin
          if (ev_go || ev_stop) begin
            state_q     <= S_ISSUE;
            cmd_code_q  <= dec_code;
            cmd_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (stop_now) pend_q <= 1'b1;
          if (hs) begin
            cmd_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            if (pend_q || stop_now) begin
              cmd_code_q <= C_STOP;
            end else if (cmd_code_q == C_STOP) begin
              state_q <= S_HALT;
`ifdef DECISION_SEQ_QUEUE_EN
              q_vld_q <= 1'b0;
`endif
            end else begin
              state_q <= S_HOLD;
              cnt_q   <= HOLD_LD;
            end
          end else if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
          end
        end
        S_HOLD, S_COOL: begin
          if (ev_stop) begin
            state_q     <= S_ISSUE;
            cmd_code_q  <= C_STOP;
            cmd_valid_q <= 1'b1;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (state_q == S_HOLD) begin
            state_q <= S_COOL;
            cnt_q   <= COOL_LD;
          end else begin
            state_q <= S_IDLE;
`ifdef DECISION_SEQ_QUEUE_EN
            if (q_vld_q || ev_go) begin
              state_q     <= S_ISSUE;
              cmd_code_q  <= ev_go ? dec_code : q_code_q;
              cmd_valid_q <= 1'b1;
              q_vld_q     <= 1'b0;
            end
`endif
          end
        end
        S_HALT: begin
          if (ev_go) begin
            state_q     <= S_ISSUE;
            cmd_code_q  <= dec_code;
            cmd_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decision_sequencer.sv
// tb_decision_sequencer: directed and random stimulus for decision_sequencer,
// checked each cycle against a behavioural reference model.
module tb_decision_sequencer;

  localparam int HOLD = 4;
  localparam int COOL = 3;
`ifdef DECISION_SEQ_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [2:0] dec_code;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       busy;
  logic       halted;
  logic [2:0] st;
  logic       dropped;
  logic       err;

  always #5 clk = ~clk;

  decision_sequencer #(
    .HOLD_CYCLES(HOLD),
    .COOL_CYCLES(COOL),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dec_valid(dec_valid),
    .dec_code(dec_code),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .busy(busy),
    .halted(halted),
    .state(st),
    .dropped(dropped),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: state number, absolute cycle at which the current
  // hold/cool phase ends, and the previous dec_valid level.
  int m_st   = 0;
  int m_code = 0;
  int m_end  = 0;
  int m_qc   = 0;
  bit m_valid, m_drop, m_err, m_pend, m_prev, m_qv;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_issue(int c);
    m_st = 1; m_code = c; m_valid = 1'b1;
  endtask

  task automatic m_capture(int c);
    if (QEN) begin
      if (m_qv) m_drop = 1'b1;
      m_qv = 1'b1; m_qc = c;
    end else begin
      m_drop = 1'b1;
    end
  endtask

  task automatic model_step();
    bit ev, stop, hs;
    int c;
    cyc++;
    m_drop = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_st = 0; m_valid = 1'b0; m_code = 0;
      m_pend = 1'b0; m_qv = 1'b0;
      m_prev = dec_valid;
      return;
    end
    ev = dec_valid && !m_prev;
    m_prev = dec_valid;
    c = int'(dec_code);
    if (ev && (c < 1 || c > 4)) begin
      m_err = 1'b1;
      ev = 1'b0;
    end
    stop = (c == 4);
    case (m_st)
      0: if (ev) m_issue(c);
      1: begin
        hs = m_valid && cmd_ready;
        if (ev && stop) begin
          if (m_code != 4) m_pend = 1'b1;
          m_qv = 1'b0;
        end else if (ev) begin
          m_capture(c);
        end
        if (hs) begin
          m_valid = 1'b0;
          if (m_pend) begin
            m_code = 4; m_pend = 1'b0;
          end else if (m_code == 4) begin
            m_st = 4; m_qv = 1'b0;
          end else begin
            m_st = 2; m_end = cyc + HOLD;
          end
        end else begin
          m_valid = 1'b1;
        end
      end
      2, 3: begin
        if (ev && stop) begin
          m_issue(4); m_qv = 1'b0;
        end else begin
          if (ev) m_capture(c);
          if (cyc == m_end) begin
            if (m_st == 2) begin
              m_st = 3; m_end = cyc + COOL;
            end else if (m_qv) begin
              m_issue(m_qc); m_qv = 1'b0;
            end else begin
              m_st = 0;
            end
          end
        end
      end
      4: if (ev && !stop) m_issue(c);
      default: ;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("state", st, m_st);
    chk("cmd_valid", cmd_valid, m_valid);
    chk("cmd_code", cmd_code, m_code);
    chk("busy", busy, (m_st >= 1 && m_st <= 3));
    chk("halted", halted, (m_st == 4));
    chk("dropped", dropped, m_drop);
    chk("err", err, m_err);
  endtask

  task automatic pulse(int c);
    dec_valid = 1'b1;
    dec_code  = 3'(c);
    tick();
    dec_valid = 1'b0;
  endtask

  task automatic wait_model(int s, int lim);
    int n = 0;
    while (m_st != s && n < lim) begin
      tick();
      n++;
    end
    if (m_st != s) begin
      checks++;
      errors++;
      $error("FAIL wait_state: observed %0d expected %0d", m_st, s);
    end
  endtask

  initial begin
    int n_hold, n_cool, n_cmd, r;
    rst = 1'b1; dec_valid = 1'b0; dec_code = 3'd0; cmd_ready = 1'b1;
    repeat (3) tick();
    chk("rst_state", st, 0);
    chk("rst_valid", cmd_valid, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Basic flow
    pulse(2);
    chk("basic_valid", cmd_valid, 1);
    chk("basic_code", cmd_code, 2);
    n_hold = 0; n_cool = 0;
    repeat (12) begin
      tick();
      if (st == 3'd2) n_hold++;
      if (st == 3'd3) n_cool++;
    end
    chk("hold_len", n_hold, HOLD);
    chk("cool_len", n_cool, COOL);
    chk("basic_idle", st, 0);

    // Backpressure
    cmd_ready = 1'b0;
    pulse(2);
    repeat (3) tick();
    chk("bp_valid", cmd_valid, 1);
    chk("bp_code", cmd_code, 2);
    cmd_ready = 1'b1;
    tick();
    chk("bp_drop", cmd_valid, 0);
    repeat (10) tick();

    // STOP preempt and halt
    pulse(1);
    repeat (2) tick();
    pulse(4);
    chk("stop_valid", cmd_valid, 1);
    chk("stop_code", cmd_code, 4);
    tick();
    chk("halt_flag", halted, 1);
    chk("halt_state", st, 4);
    pulse(4);
    chk("halt_stay", st, 4);
    chk("halt_novalid", cmd_valid, 0);
    tick();
    pulse(3);
    chk("resume_state", st, 1);
    chk("resume_code", cmd_code, 3);
    chk("resume_halted", halted, 0);
    repeat (10) tick();

    // Level held high gives one command
    dec_valid = 1'b1; dec_code = 3'd1;
    n_cmd = 0;
    repeat (20) begin
      tick();
      if (cmd_valid) n_cmd++;
    end
    chk("level_once", n_cmd, 1);
    dec_valid = 1'b0;
    repeat (3) tick();

    // Illegal code
    pulse(6);
    chk("ill_err", err, 1);
    chk("ill_valid", cmd_valid, 0);
    chk("ill_state", st, 0);
    tick();
    chk("err_oneshot", err, 0);

    // Decision during COOL
    pulse(1);
    wait_model(3, 20);
    pulse(3);
    chk("cool_drop", dropped, !QEN);
    chk("cool_novalid", cmd_valid, 0);
    repeat (12) tick();

`ifdef DECISION_SEQ_QUEUE_EN
    pulse(1);
    wait_model(2, 10);
    pulse(2);
    chk("q_first", dropped, 0);
    tick();
    pulse(3);
    chk("q_over", dropped, 1);
    wait_model(1, 20);
    chk("q_code", cmd_code, 3);
    chk("q_valid", cmd_valid, 1);
    repeat (12) tick();
`endif

    // Reset mid-handshake with dec_valid left high
    cmd_ready = 1'b0;
    dec_valid = 1'b1; dec_code = 3'd2;
    tick();
    chk("mid_valid", cmd_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_state", st, 0);
    chk("mid_rst_code", cmd_code, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", cmd_valid, 0);
    chk("post_rst_state", st, 0);
    dec_valid = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // Random traffic
    repeat (1500) begin
      rst = ($urandom % 300) == 0;
      if (($urandom % 3) == 0) dec_valid = ~dec_valid;
      r = int'($urandom % 10);
      dec_code = (r < 7) ? 3'(r % 4 + 1) : 3'($urandom % 8);
      cmd_ready = ($urandom % 4) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
